// File: rtl/memtest_sequencer.sv
// Run controller for the memtest BIST datapath: sequences reset, write/read sweeps,
// a settle window and a go-flag check, and keeps pass/fail statistics.
module memtest_sequencer #(
  parameter int ADDR_W = 5,
  parameter int SIG_W  = 32,
  parameter int SETTLE = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             clr_stats,
  input  logic [SIG_W-1:0] ref_in,
  input  logic             go,
  output logic             mt_rst,
  output logic             test,
  output logic [SIG_W-1:0] ref_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_WRITE, S_READ, S_SETTLE, S_CHECK
  } state_t;

  localparam logic [ADDR_W:0] SWEEP_LAST  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] SETTLE_LAST = (ADDR_W+1)'(SETTLE - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W:0]   r_cnt;
  logic              w_accept;
  logic              w_finish;
  logic              w_mt_rst;
  logic              w_test;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      // Counter restarts on every state entry so each phase counts from 0.
      r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mt_rst     = 1'b0;
    w_test       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mt_rst = 1'b1;
        if (start && !abort) begin
          w_accept     = 1'b1;
          w_state_next = S_CLR;
        end
      end
      S_CLR: begin
        w_mt_rst     = 1'b1;
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_test = 1'b1;
        if (r_cnt == SWEEP_LAST) w_state_next = S_READ;
      end
      S_READ: begin
        w_test = 1'b1;
        if (r_cnt == SWEEP_LAST) w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_mt_rst     = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
    if (abort && r_state != S_IDLE) w_state_next = S_IDLE;
  end

  // An abort landing on the CHECK cycle discards the result entirely.
  assign w_finish = (r_state == S_CHECK) && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_sig  <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_cnt <= '0;
    end else begin
      done <= w_finish;
      if (w_accept) ref_sig <= ref_in;
      if (w_finish) pass <= go;
      if (clr_stats)
        fail_cnt <= '0;
      else if (w_finish && !go && fail_cnt != {CNT_W{1'b1}})
        fail_cnt <= fail_cnt + 1'b1;
    end
  end

  assign mt_rst = w_mt_rst;
  assign test   = w_test;
  assign busy   = (r_state != S_IDLE);

endmodule
